ahb_slave_mem: RTL

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem_pkg.sv | 61 ++++++
 rtl/ahb_slave_mem_array.sv | 46 ++++
 rtl/ahb_slave_mem.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_mem_pkg.sv
// ============================================================================
// Module  : ahb_slave_mem_pkg
// Purpose : Shared AMBA AHB encodings (HTRANS, HSIZE, HRESP, HBURST, W_BURST)
//           and helpers for the ahb_slave_mem block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ahb_slave_mem_pkg;

  // HTRANS
  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

  // HSIZE
  localparam logic [2:0] c_HSIZE_BYTE = 3'b000;
  localparam logic [2:0] c_HSIZE_HALF = 3'b001;
  localparam logic [2:0] c_HSIZE_WORD = 3'b010;

  // HRESP
  localparam logic [1:0] c_HRESP_OKAY  = 2'b00;
  localparam logic [1:0] c_HRESP_ERROR = 2'b01;
  localparam logic [1:0] c_HRESP_RETRY = 2'b10;
  localparam logic [1:0] c_HRESP_SPLIT = 2'b11;

  // HBURST
  localparam int         W_BURST         = 3;
  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
  localparam logic [2:0] c_HBURST_INCR   = 3'b001;
  localparam logic [2:0] c_HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] c_HBURST_INCR4  = 3'b011;
  localparam logic [2:0] c_HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] c_HBURST_INCR8  = 3'b101;
  localparam logic [2:0] c_HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] c_HBURST_INCR16 = 3'b111;

  // Slave control state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Little-endian byte lanes touched by a transfer of the given size/offset
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      c_HSIZE_BYTE: be = 4'b0001 << a;
      c_HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default:      be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_slave_mem_array.sv
// ============================================================================
// Module  : ahb_slave_mem_array
// Purpose : 2^AW x 32 register file, byte-enable synchronous write,
//           asynchronous read, asynchronous reset of every word to zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_slave_mem_array
  import ahb_slave_mem_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  localparam int c_DEPTH = 2 ** AW;

  logic [31:0] r_mem [0:c_DEPTH-1];

  // Byte-lane writes; reset clears the whole array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/ahb_slave_mem.sv
// ============================================================================
// Module  : ahb_slave_mem
// Purpose : AHB-Lite memory slave with programmable wait states.
//           Optional macro AHB_SLAVE_ERROR_RESP_EN enables the two-cycle
//           ERROR response for illegal transfers; without it illegal
//           transfers complete OKAY, writes are dropped and reads return 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_slave_mem
  import ahb_slave_mem_pkg::*;
#(
  parameter int          AW          = 6,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                i_HSEL,
  input  logic [31:0]         i_HADDR,
  input  logic [1:0]          i_HTRANS,
  input  logic                i_HWRITE,
  input  logic [2:0]          i_HSIZE,
  input  logic [W_BURST-1:0]  i_HBURST,
  input  logic [31:0]         i_HWDATA,
  input  logic                i_HREADY,
  output logic [31:0]         o_HRDATA,
  output logic [1:0]          o_HRESP,
  output logic                o_HREADYOUT
);

  localparam logic [32:0] c_LIMIT   = 33'd4 << AW;
  localparam logic [3:0]  c_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Address-phase decode
  logic [31:0]   w_offset;
  logic [AW-1:0] w_word;
  logic          w_capture;
  logic          w_in_range;
  logic          w_size_ok;
  logic          w_align_ok;
  logic          w_legal;
  logic          w_err;
  logic [3:0]    w_be;

  assign w_offset   = i_HADDR - BASE_ADDR;
  assign w_word     = w_offset[AW+1:2];
  assign w_capture  = i_HSEL & i_HREADY & i_HTRANS[1];
  assign w_in_range = ({1'b0, w_offset} < c_LIMIT);
  assign w_size_ok  = (i_HSIZE <= c_HSIZE_WORD);
  assign w_align_ok = !(((i_HSIZE == c_HSIZE_HALF) && i_HADDR[0]) ||
                        ((i_HSIZE == c_HSIZE_WORD) && (i_HADDR[1:0] != 2'b00)));
  assign w_legal    = w_in_range & w_size_ok & w_align_ok;
  assign w_be       = byte_en(i_HSIZE, i_HADDR[1:0]);

`ifdef AHB_SLAVE_ERROR_RESP_EN
  assign w_err = !w_legal;
`else
  assign w_err = 1'b0;
`endif

  // Burst type is accepted but each beat is decoded on its own address
  logic w_unused;
  assign w_unused = ^{i_HBURST, w_offset[31:AW+2]};

  // Captured data-phase context and FSM state
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_valid;
  logic          r_write;
  logic          r_legal;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic          r_readyout;
  logic [1:0]    r_resp;

  // Control FSM: address capture, wait-state counting, error sequencing
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_valid    <= 1'b0;
      r_write    <= 1'b0;
      r_legal    <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'd0;
      r_readyout <= 1'b1;
      r_resp     <= c_HRESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          // Data phase ends here when the bus is ready; sample next address
          if (i_HREADY) begin
            r_state    <= ST_IDLE;
            r_readyout <= 1'b1;
            r_resp     <= c_HRESP_OKAY;
            r_valid    <= w_capture;
            r_write    <= i_HWRITE;
            r_legal    <= w_legal;
            r_addr     <= w_word;
            r_be       <= w_be;
            if (w_capture) begin
              if (w_err) begin
                r_state    <= ST_ERR1;
                r_readyout <= 1'b0;
                r_resp     <= c_HRESP_ERROR;
              end else if (WAIT_STATES != 0) begin
                r_state    <= ST_WAIT;
                r_cnt      <= c_WS_LOAD;
                r_readyout <= 1'b0;
              end
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= ST_IDLE;
            r_readyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef AHB_SLAVE_ERROR_RESP_EN
        ST_ERR1: begin
          r_state    <= ST_ERR2;
          r_readyout <= 1'b1;
          r_resp     <= c_HRESP_ERROR;
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_readyout <= 1'b1;
          r_resp     <= c_HRESP_OKAY;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

  // Storage access: commit on the edge that ends a legal write data phase
  logic        w_complete;
  logic        w_we;
  logic [31:0] w_rdata;

  assign w_complete = (r_state == ST_IDLE) & r_valid & r_legal;
  assign w_we       = w_complete & r_write & i_HREADY;

  ahb_slave_mem_array #(
    .AW (AW)
  ) u_array (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_we    (w_we),
    .i_be    (r_be),
    .i_addr  (r_addr),
    .i_wdata (i_HWDATA),
    .o_rdata (w_rdata)
  );

  assign o_HRDATA    = (w_complete & !r_write) ? w_rdata : 32'h0;
  assign o_HRESP     = r_resp;
  assign o_HREADYOUT = r_readyout;

endmodule

`default_nettype wire
